// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port RAM: default geometry and FSM states.
package mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge: takes each byte from new_i where be_i is set, otherwise
// from old_i.
//   old_i    : current word
//   new_i    : incoming word
//   be_i     : byte enables, bit i selects bits 8i+7:8i of new_i
//   merged_o : resulting word
module mem_byte_merge #(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] new_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < BE_W; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only.
// After reset the array is cleared one word per cycle before either port
// accepts requests.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing word cnt_q each cycle; ports not ready
// ST_RUN  | normal operation; leaves only through reset
//
// Ports:
//   clock, reset (async, active-low)
//   a_req/a_we/a_be/a_addr/a_wdata -> a_ready, a_rdata, a_rvalid, a_err
//   b_req/b_addr                   -> b_ready, b_rdata, b_rvalid
//   init_done                      : clear sweep complete
module dual_port_ram
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [BE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_err,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ready,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              a_rvalid_q, a_rvalid_d;
  logic              a_err_q, a_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              run;
  logic              a_acc, b_acc;
  logic              a_in_range, b_in_range;
  logic [ADDR_W-1:0] a_idx, b_idx;
  logic [DATA_W-1:0] a_old, b_word, a_merged;
  logic              a_wr_en, b_hit;

  assign run       = (state_q == ST_RUN);
  assign a_ready   = run;
  assign b_ready   = run;
  assign init_done = run;

  assign a_acc = a_req & run;
  assign b_acc = b_req & run;

  assign a_in_range = (32'(a_addr) < 32'(DEPTH));
  assign b_in_range = (32'(b_addr) < 32'(DEPTH));

  // Clamp indices so the array is never addressed past its last word.
  assign a_idx  = a_in_range ? a_addr : '0;
  assign b_idx  = b_in_range ? b_addr : '0;
  assign a_old  = mem_q[a_idx];
  assign b_word = mem_q[b_idx];

  // One merge instance serves both the array write and the port B bypass.
  mem_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_i    (a_old),
    .new_i    (a_wdata),
    .be_i     (a_be),
    .merged_o (a_merged)
  );

  assign a_wr_en = a_acc & a_we & a_in_range;
  assign b_hit   = a_wr_en & (b_addr == a_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    a_rvalid_d = a_acc & ~a_we;
    a_err_d    = a_acc & ~a_in_range;
    a_rdata_d  = a_rdata_q;
    if (a_rvalid_d) a_rdata_d = a_in_range ? a_old : '0;

    b_rvalid_d = b_acc;
    b_rdata_d  = b_rdata_q;
    if (b_acc) begin
      if (!b_in_range) b_rdata_d = '0;
      else if (b_hit)  b_rdata_d = a_merged;
      else             b_rdata_d = b_word;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      a_err_q    <= a_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rvalid_q <= b_rvalid_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Storage has no reset; the ST_INIT sweep is what clears it.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) mem_q[cnt_q] <= '0;
    else if (a_wr_en)       mem_q[a_idx] <= a_merged;
  end

  assign a_rvalid = a_rvalid_q;
  assign a_err    = a_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: two instances (DEPTH 1024 and DEPTH 1000) share
// one stimulus stream and are checked every cycle against an array model.
module tb_dual_port_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req;
  logic [3:0]  a_be;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata;

  logic        d0_a_ready, d0_a_rvalid, d0_a_err, d0_b_ready, d0_b_rvalid, d0_init_done;
  logic [31:0] d0_a_rdata, d0_b_rdata;
  logic        d1_a_ready, d1_a_rvalid, d1_a_err, d1_b_ready, d1_b_rvalid, d1_init_done;
  logic [31:0] d1_a_rdata, d1_b_rdata;

  always #5 clock = ~clock;

  dual_port_ram #(.DATA_W(32), .DEPTH(1024)) u_dut0 (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(d0_a_ready), .a_rdata(d0_a_rdata), .a_rvalid(d0_a_rvalid), .a_err(d0_a_err),
    .b_req(b_req), .b_addr(b_addr), .b_ready(d0_b_ready), .b_rdata(d0_b_rdata),
    .b_rvalid(d0_b_rvalid), .init_done(d0_init_done)
  );

  dual_port_ram #(.DATA_W(32), .DEPTH(1000)) u_dut1 (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(d1_a_ready), .a_rdata(d1_a_rdata), .a_rvalid(d1_a_rvalid), .a_err(d1_a_err),
    .b_req(b_req), .b_addr(b_addr), .b_ready(d1_b_ready), .b_rdata(d1_b_rdata),
    .b_rvalid(d1_b_rvalid), .init_done(d1_init_done)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          dep [2] = '{1024, 1000};
  logic [31:0] mm  [2][1024];
  int          n_edges [2];
  logic        e_rdy [2], e_arv [2], e_aerr [2], e_brv [2];
  logic [31:0] e_ard [2], e_brd [2];

  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        n_edges[i] = 0;
        e_rdy[i] = 1'b0; e_arv[i] = 1'b0; e_aerr[i] = 1'b0; e_brv[i] = 1'b0;
        e_ard[i] = '0;   e_brd[i] = '0;
      end else begin
        e_arv[i] = 1'b0; e_aerr[i] = 1'b0; e_brv[i] = 1'b0;
        if (n_edges[i] < dep[i]) begin
          n_edges[i]++;
          if (n_edges[i] == dep[i])
            for (int w = 0; w < 1024; w++) mm[i][w] = '0;
        end else begin
          if (a_req) begin
            if (int'(a_addr) >= dep[i]) begin
              e_aerr[i] = 1'b1;
              if (!a_we) begin e_arv[i] = 1'b1; e_ard[i] = '0; end
            end else if (a_we) begin
              for (int k = 0; k < 4; k++)
                if (a_be[k]) mm[i][a_addr][8*k +: 8] = a_wdata[8*k +: 8];
            end else begin
              e_arv[i] = 1'b1; e_ard[i] = mm[i][a_addr];
            end
          end
          if (b_req) begin
            e_brv[i] = 1'b1;
            e_brd[i] = (int'(b_addr) >= dep[i]) ? 32'h0 : mm[i][b_addr];
          end
        end
        e_rdy[i] = (n_edges[i] >= dep[i]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        g_ardy [2], g_arv [2], g_aerr [2], g_brdy [2], g_brv [2], g_done [2];
  logic [31:0] g_ard [2], g_brd [2];
  assign g_ardy[0] = d0_a_ready;  assign g_ardy[1] = d1_a_ready;
  assign g_arv[0]  = d0_a_rvalid; assign g_arv[1]  = d1_a_rvalid;
  assign g_aerr[0] = d0_a_err;    assign g_aerr[1] = d1_a_err;
  assign g_brdy[0] = d0_b_ready;  assign g_brdy[1] = d1_b_ready;
  assign g_brv[0]  = d0_b_rvalid; assign g_brv[1]  = d1_b_rvalid;
  assign g_done[0] = d0_init_done; assign g_done[1] = d1_init_done;
  assign g_ard[0]  = d0_a_rdata;  assign g_ard[1]  = d1_a_rdata;
  assign g_brd[0]  = d0_b_rdata;  assign g_brd[1]  = d1_b_rdata;

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d a_ready", i),   32'(g_ardy[i]), 32'(e_rdy[i]));
      chk($sformatf("dut%0d b_ready", i),   32'(g_brdy[i]), 32'(e_rdy[i]));
      chk($sformatf("dut%0d init_done", i), 32'(g_done[i]), 32'(e_rdy[i]));
      chk($sformatf("dut%0d a_rvalid", i),  32'(g_arv[i]),  32'(e_arv[i]));
      chk($sformatf("dut%0d a_err", i),     32'(g_aerr[i]), 32'(e_aerr[i]));
      chk($sformatf("dut%0d b_rvalid", i),  32'(g_brv[i]),  32'(e_brv[i]));
      chk($sformatf("dut%0d a_rdata", i),   g_ard[i], e_ard[i]);
      chk($sformatf("dut%0d b_rdata", i),   g_brd[i], e_brd[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic ar, input logic aw, input logic [3:0] be,
                     input logic [9:0] aa, input logic [31:0] wd,
                     input logic br, input logic [9:0] ba);
    a_req = ar; a_we = aw; a_be = be; a_addr = aa; a_wdata = wd;
    b_req = br; b_addr = ba;
    @(posedge clock); #1;
    a_req = 1'b0; b_req = 1'b0;
  endtask

  // Counts edges after reset release until each instance becomes ready.
  task automatic wait_init(output int r0, output int r1);
    r0 = 0; r1 = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clock); #1;
      if (d1_a_ready && r1 == 0) r1 = k;
      if (d0_a_ready && r0 == 0) r0 = k;
      if (r0 != 0 && r1 != 0) break;
    end
  endtask

  int r0, r1;

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0; b_req = 0; b_addr = 0;
    #2 reset = 1'b0;
    #1;
    chk("reset a_ready", 32'(d0_a_ready), 32'd0);
    chk("reset a_rdata", d0_a_rdata, 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    wait_init(r0, r1);
    chk("init cycles dut0", 32'(r0), 32'd1024);
    chk("init cycles dut1", 32'(r1), 32'd1000);
    chk("init_done dut0", 32'(d0_init_done), 32'd1);

    cyc(1, 0, 4'h0, 10'd5, 0, 0, 0);
    chk("read 5 rvalid", 32'(d0_a_rvalid), 32'd1);
    chk("read 5 rdata", d0_a_rdata, 32'h0000_0000);

    cyc(1, 1, 4'hF, 10'h200, 32'hDEAD_BEEF, 0, 0);
    chk("write no rvalid", 32'(d0_a_rvalid), 32'd0);
    cyc(1, 0, 4'h0, 10'h200, 0, 0, 0);
    chk("read 200 rvalid", 32'(d0_a_rvalid), 32'd1);
    chk("read 200 rdata", d0_a_rdata, 32'hDEAD_BEEF);

    cyc(1, 1, 4'b0010, 10'h200, 32'h0000_AA00, 0, 0);
    cyc(1, 0, 4'h0, 10'h200, 0, 0, 0);
    chk("byte merge rdata", d0_a_rdata, 32'hDEAD_AAEF);

    cyc(1, 1, 4'h0, 10'h200, 32'hFFFF_FFFF, 0, 0);
    cyc(1, 0, 4'h0, 10'h200, 0, 0, 0);
    chk("be0 write rdata", d0_a_rdata, 32'hDEAD_AAEF);
    cyc(0, 0, 4'h0, 10'h0, 0, 0, 0);
    chk("hold rvalid", 32'(d0_a_rvalid), 32'd0);
    chk("hold rdata", d0_a_rdata, 32'hDEAD_AAEF);

    cyc(1, 1, 4'hF, 10'h010, 32'h1234_5678, 1, 10'h010);
    chk("bypass b_rvalid", 32'(d0_b_rvalid), 32'd1);
    chk("bypass b_rdata", d0_b_rdata, 32'h1234_5678);

    cyc(1, 0, 4'h0, 10'd1000, 0, 1, 10'd1000);
    chk("oor read a_err", 32'(d1_a_err), 32'd1);
    chk("oor read a_rvalid", 32'(d1_a_rvalid), 32'd1);
    chk("oor read a_rdata", d1_a_rdata, 32'h0);
    chk("oor b_rdata", d1_b_rdata, 32'h0);
    cyc(1, 1, 4'hF, 10'd1000, 32'hFFFF_FFFF, 0, 0);
    chk("oor write a_err", 32'(d1_a_err), 32'd1);
    chk("oor write a_rvalid", 32'(d1_a_rvalid), 32'd0);
    cyc(1, 0, 4'h0, 10'd999, 0, 0, 0);
    chk("oor err pulse ends", 32'(d1_a_err), 32'd0);
    chk("read 999 rdata", d1_a_rdata, 32'h0);

    for (int n = 0; n < 4000; n++) begin
      logic [9:0] aa, ba;
      int unsigned sel;
      sel = $urandom_range(7);
      if (sel == 0)      aa = 10'(1000 + $urandom_range(23));
      else if (sel < 4)  aa = 10'($urandom_range(15));
      else               aa = 10'($urandom_range(1023));
      sel = $urandom_range(2);
      if (sel == 0)      ba = aa;
      else if (sel == 1) ba = 10'($urandom_range(15));
      else               ba = 10'($urandom_range(1023));
      a_req = ($urandom_range(3) != 0); a_we = $urandom_range(1) == 1;
      a_be = 4'($urandom_range(15)); a_addr = aa; a_wdata = $urandom;
      b_req = ($urandom_range(2) != 0); b_addr = ba;
      @(posedge clock); #1;
    end
    a_req = 0; b_req = 0;

    cyc(1, 1, 4'hF, 10'h200, 32'hCAFE_F00D, 0, 0);
    cyc(1, 0, 4'h0, 10'h200, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("abort a_rvalid", 32'(d0_a_rvalid), 32'd0);
    chk("abort a_rdata", d0_a_rdata, 32'h0);
    chk("abort a_ready", 32'(d0_a_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    wait_init(r0, r1);
    chk("reinit cycles dut0", 32'(r0), 32'd1024);
    cyc(1, 0, 4'h0, 10'h200, 0, 0, 0);
    chk("reinit read 200", d0_a_rdata, 32'h0000_0000);
    chk("reinit rvalid", 32'(d0_a_rvalid), 32'd1);

    repeat (2) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
